// File: rtl/rtc_access_sched_if.sv
// RTC bus handshake between the access scheduler (master) and the RTC bus interface (slave).
interface rtc_access_sched_if;
  logic       bus_req;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_ack;
  logic [7:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/rtc_access_sched.sv
// RTC access scheduler: periodic register scan arbitrated against one-deep user writes.
// Optional ack timeout enabled by defining RTC_TIMEOUT_EN.
module rtc_access_sched #(
  parameter int unsigned N_REGS      = 6,
  parameter logic [7:0]  BASE_ADDR   = 8'h21,
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      prog_mode,
  input  logic                      wr_req,
  input  logic [2:0]                wr_idx,
  input  logic [7:0]                wr_data,
  rtc_access_sched_if.master        bus,
  output logic                      rd_valid,
  output logic [2:0]                rd_idx,
  output logic [7:0]                rd_data,
  output logic                      select,
  output logic                      busy,
  output logic                      err
);

  localparam int unsigned TW       = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TMR_LAST = TW'(SCAN_DIV - 1);
  localparam logic [2:0]  LAST_IDX = 3'(N_REGS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          scan_pending;
  logic [2:0]    scan_idx;
  logic          slot_full;
  logic [2:0]    slot_idx;
  logic [7:0]    slot_data;
  logic          prog_q;

  logic expire;
  logic fall;
  logic tmo_hit;
  logic done;

  assign expire = (timer == TMR_LAST);
  assign fall   = prog_q & ~prog_mode;
  assign done   = bus.bus_ack | tmo_hit;

`ifdef RTC_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt;
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Scheduler FSM plus scan timer, write slot and prog_mode tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      rd_valid      <= 1'b0;
      rd_idx        <= '0;
      rd_data       <= '0;
      select        <= 1'b1;
      busy          <= 1'b0;
      err           <= 1'b0;
      timer         <= '0;
      scan_pending  <= 1'b0;
      scan_idx      <= '0;
      slot_full     <= 1'b0;
      slot_idx      <= '0;
      slot_data     <= '0;
      prog_q        <= 1'b0;
`ifdef RTC_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      timer    <= expire ? '0 : timer + TW'(1);
      prog_q   <= prog_mode;
      select   <= ~prog_mode;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      if (expire) scan_pending <= 1'b1;
      if (wr_req) begin
        slot_full <= 1'b1;
        slot_idx  <= wr_idx;
        slot_data <= wr_data;
      end
`ifdef RTC_TIMEOUT_EN
      tmo_cnt <= tmo_cnt + CW'(1);
`endif

      case (state)
        IDLE: begin
          // Pending write wins; scans also wait out the cycle prog_mode falls.
          if (slot_full) begin
            state         <= WRITE;
            busy          <= 1'b1;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= 1'b1;
            bus.bus_addr  <= BASE_ADDR + 8'(slot_idx);
            bus.bus_wdata <= slot_data;
            if (!wr_req) slot_full <= 1'b0;
`ifdef RTC_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end else if (scan_pending && !prog_mode && !prog_q) begin
            state        <= READ;
            busy         <= 1'b1;
            bus.bus_req  <= 1'b1;
            bus.bus_we   <= 1'b0;
            bus.bus_addr <= BASE_ADDR + 8'(scan_idx);
`ifdef RTC_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        READ: begin
          if (done) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bus.bus_req <= 1'b0;
            err         <= ~bus.bus_ack;
            if (bus.bus_ack) begin
              rd_valid <= 1'b1;
              rd_idx   <= scan_idx;
              rd_data  <= bus.bus_rdata;
            end
            if (scan_idx == LAST_IDX) begin
              scan_idx     <= '0;
              scan_pending <= expire;
            end else begin
              scan_idx <= scan_idx + 3'd1;
            end
          end
        end
        WRITE: begin
          if (done) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bus.bus_req <= 1'b0;
            err         <= ~bus.bus_ack;
          end
        end
        default: state <= IDLE;
      endcase

      // Leaving programming mode forces a full refresh from register 0.
      if (fall) begin
        scan_pending <= 1'b1;
        scan_idx     <= '0;
      end
    end
  end

endmodule
